// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch path (IF) and the
// load/store unit (D). Only one transaction is outstanding at a time.
// Data requests normally win. A saturating starvation counter bounds how many
// data grants may be issued while fetch is waiting. A fetch flush discards an
// in-flight fetch response so stale instructions never reach IF.
//
// The request path is a zero-cycle pass-through from the winner to memory.
// The response path routes mem_resp_valid to the owner in the same cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req_valid/addr/ready  fetch request handshake
//   if_resp_valid/data       fetch response (one-cycle pulse)
//   if_flush                 drop outstanding or same-cycle fetch
//   d_req_valid/addr/wmask/wdata/ready   data request handshake (wmask 0 = read)
//   d_resp_valid/data        data response (pulse for reads and writes)
//   mem_req_valid/addr/wmask/wdata/ready memory request port
//   mem_resp_valid/data      memory response (one pulse per accepted request)
//
// Parameter
//   STARVE_LIMIT             max consecutive data grants while fetch waits (1..15)

module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        if_flush,

   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   input  logic [3:0]  d_req_wmask,
   input  logic [31:0] d_req_wdata,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   output logic [31:0] d_resp_data,

   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   output logic [3:0]  mem_req_wmask,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,   // fetch outstanding
      BUSY_D,    // data outstanding
      DRAIN      // flushed fetch outstanding; its response is swallowed
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;

   logic idle;
   logic if_eff;
   logic fetch_win;
   logic data_win;
   logic accept;

   // Grant decision. Recomputed every IDLE cycle; nothing is locked while
   // waiting for mem_req_ready, so a requester that drops valid loses the
   // grant to the other one.
   assign idle      = (state == IDLE) && !rst;
   assign if_eff    = if_req_valid && !if_flush;
   assign fetch_win = if_eff && (!d_req_valid || (starve_cnt == LIMIT));
   assign data_win  = d_req_valid && !fetch_win;
   assign accept    = idle && (fetch_win || data_win) && mem_req_ready;

   // NOTE: every output driven here gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = d_req_addr;
      mem_req_wmask = d_req_wmask;
      mem_req_wdata = d_req_wdata;
      if_req_ready  = 1'b0;
      d_req_ready   = 1'b0;

      if (fetch_win) begin
         mem_req_addr  = if_req_addr;
         mem_req_wmask = 4'h0;
         mem_req_wdata = 32'h0;
      end

      if (idle) begin
         mem_req_valid = fetch_win || data_win;
         if_req_ready  = fetch_win && mem_req_ready;
         d_req_ready   = data_win && mem_req_ready;
      end
   end

   // Response data is a straight copy; only the valids are steered.
   // A flush arriving with the fetch response kills the pulse.
   assign if_resp_data  = mem_resp_data;
   assign d_resp_data   = mem_resp_data;
   assign if_resp_valid = !rst && (state == BUSY_IF) && mem_resp_valid && !if_flush;
   assign d_resp_valid  = !rst && (state == BUSY_D) && mem_resp_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (fetch_win) begin
                     state      <= BUSY_IF;
                     starve_cnt <= 4'd0;
                  end else begin
                     state <= BUSY_D;
                     // Only count data grants that actually made fetch wait.
                     if (if_eff && (starve_cnt != LIMIT))
                        starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            BUSY_IF: begin
               // A response wins over a flush in the same cycle: the pulse is
               // already suppressed, and the port is free again.
               if (mem_resp_valid)
                  state <= IDLE;
               else if (if_flush)
                  state <= DRAIN;
            end
            BUSY_D, DRAIN: begin
               if (mem_resp_valid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (STARVE_LIMIT = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit after that, well clear of the next edge.

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        if_flush;
   logic        d_req_valid;
   logic [31:0] d_req_addr;
   logic [3:0]  d_req_wmask;
   logic [31:0] d_req_wdata;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic [3:0]  mem_req_wmask;
   logic [31:0] mem_req_wdata;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_valid   (if_req_valid),
      .if_req_addr    (if_req_addr),
      .if_req_ready   (if_req_ready),
      .if_resp_valid  (if_resp_valid),
      .if_resp_data   (if_resp_data),
      .if_flush       (if_flush),
      .d_req_valid    (d_req_valid),
      .d_req_addr     (d_req_addr),
      .d_req_wmask    (d_req_wmask),
      .d_req_wdata    (d_req_wdata),
      .d_req_ready    (d_req_ready),
      .d_resp_valid   (d_resp_valid),
      .d_resp_data    (d_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wmask  (mem_req_wmask),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction with single-cycle memory latency while requesters hold
   // their valids: records who was granted in the IDLE cycle.
   task automatic run_txn(output logic got_if, output logic got_d);
      mem_resp_valid = 1'b0;
      settle();
      got_if = if_req_ready;
      got_d  = d_req_ready;
      tick();
      mem_resp_valid = 1'b1;
      settle();
      tick();
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      logic       g_if, g_d;
      logic [9:0] pattern;
      int         if_cnt, d_cnt;
      logic [31:0] if_seen;

      rst = 1'b1;
      if_req_valid = 0; if_req_addr = 0; if_flush = 0;
      d_req_valid = 0; d_req_addr = 0; d_req_wmask = 0; d_req_wdata = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
      tick();
      tick();

      // ---- Outputs quiet during reset even with everything asserted ----
      if_req_valid = 1; d_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
      settle();
      check1("rst_mem_req_valid", mem_req_valid, 1'b0);
      check1("rst_if_req_ready", if_req_ready, 1'b0);
      check1("rst_d_req_ready", d_req_ready, 1'b0);
      check1("rst_if_resp_valid", if_resp_valid, 1'b0);
      check1("rst_d_resp_valid", d_resp_valid, 1'b0);
      tick();
      if_req_valid = 0; d_req_valid = 0; mem_resp_valid = 0;
      rst = 0;
      tick();

      // ---- Fetch only, 3-cycle memory latency ----
      if_req_valid = 1; if_req_addr = 32'h1000; mem_req_ready = 1;
      settle();
      check1("f1_mem_req_valid", mem_req_valid, 1'b1);
      check32("f1_mem_req_addr", mem_req_addr, 32'h1000);
      check32("f1_mem_req_wmask", {28'h0, mem_req_wmask}, 32'h0);
      check32("f1_mem_req_wdata", mem_req_wdata, 32'h0);
      check1("f1_if_req_ready", if_req_ready, 1'b1);
      check1("f1_d_req_ready", d_req_ready, 1'b0);
      tick();
      if_cnt = 0; d_cnt = 0; if_seen = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if_req_valid   = (i < 2);
         mem_resp_valid = (i == 2);
         mem_resp_data  = (i == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
         settle();
         if (i < 2) begin
            check1("f1_busy_mem_req_valid", mem_req_valid, 1'b0);
            check1("f1_busy_if_req_ready", if_req_ready, 1'b0);
         end
         if (if_resp_valid) begin
            if_cnt++;
            if_seen = if_resp_data;
         end
         if (d_resp_valid) d_cnt++;
         tick();
      end
      mem_resp_valid = 0;
      check32("f1_if_resp_count", 32'(if_cnt), 32'd1);
      check32("f1_if_resp_data", if_seen, 32'hDEADBEEF);
      check32("f1_d_resp_count", 32'(d_cnt), 32'd0);

      // ---- Simultaneous fetch and data write: data first ----
      if_req_valid = 1; if_req_addr = 32'h1004;
      d_req_valid = 1; d_req_addr = 32'h2000; d_req_wmask = 4'hF; d_req_wdata = 32'h55;
      settle();
      check1("sim_d_req_ready", d_req_ready, 1'b1);
      check1("sim_if_req_ready", if_req_ready, 1'b0);
      check32("sim_mem_req_addr", mem_req_addr, 32'h2000);
      check32("sim_mem_req_wmask", {28'h0, mem_req_wmask}, 32'hF);
      check32("sim_mem_req_wdata", mem_req_wdata, 32'h55);
      tick();
      d_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h0;
      settle();
      check1("sim_d_resp_valid", d_resp_valid, 1'b1);
      check1("sim_if_resp_valid_on_d", if_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0;
      settle();
      check1("sim_if_granted_next", if_req_ready, 1'b1);
      check32("sim_if_addr", mem_req_addr, 32'h1004);
      check32("sim_if_wmask", {28'h0, mem_req_wmask}, 32'h0);
      tick();
      if_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h1234;
      settle();
      check1("sim_if_resp_valid", if_resp_valid, 1'b1);
      check32("sim_if_resp_data", if_resp_data, 32'h1234);
      check1("sim_d_resp_valid_on_if", d_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0;

      // ---- Starvation bound: D,D,D,D,IF,D,D,D,D,IF ----
      if_req_valid = 1; if_req_addr = 32'h1100;
      d_req_valid = 1; d_req_addr = 32'h2100; d_req_wmask = 4'h0;
      pattern = 10'b1000010000;   // bit i set = fetch expected on grant i
      for (int i = 0; i < 10; i++) begin
         run_txn(g_if, g_d);
         check1($sformatf("starve_if_grant_%0d", i), g_if, pattern[i]);
         check1($sformatf("starve_d_grant_%0d", i), g_d, !pattern[i]);
      end
      if_req_valid = 0; d_req_valid = 0;

      // ---- Flush while fetch in flight ----
      if_req_valid = 1; if_req_addr = 32'h3000;
      settle();
      check1("fl_if_accept", if_req_ready, 1'b1);
      tick();
      if_req_valid = 0; if_flush = 1;
      settle();
      check1("fl_no_resp_flush_cycle", if_resp_valid, 1'b0);
      tick();
      if_flush = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE0001;
      settle();
      check1("fl_drain_if_resp", if_resp_valid, 1'b0);
      check1("fl_drain_d_resp", d_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0;
      d_req_valid = 1; d_req_addr = 32'h4000; d_req_wmask = 4'h0;
      settle();
      check1("fl_next_d_accept", d_req_ready, 1'b1);
      tick();
      d_req_valid = 0; mem_resp_valid = 1;
      settle();
      check1("fl_next_d_resp", d_resp_valid, 1'b1);
      tick();
      mem_resp_valid = 0;

      // ---- Flush concurrent with fetch response; flush masks IDLE fetch ----
      if_req_valid = 1; if_req_addr = 32'h3100;
      settle();
      check1("flc_if_accept", if_req_ready, 1'b1);
      tick();
      if_req_valid = 0; if_flush = 1; mem_resp_valid = 1;
      settle();
      check1("flc_if_resp_dropped", if_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0; if_req_valid = 1;
      settle();
      check1("flc_idle_mask_mem_valid", mem_req_valid, 1'b0);
      check1("flc_idle_mask_if_ready", if_req_ready, 1'b0);
      if_flush = 0; if_req_valid = 0;
      d_req_valid = 1; d_req_addr = 32'h4100;
      settle();
      check1("flc_idle_d_accept", d_req_ready, 1'b1);
      tick();
      d_req_valid = 0; mem_resp_valid = 1;
      settle();
      check1("flc_d_resp", d_resp_valid, 1'b1);
      tick();
      mem_resp_valid = 0;

      // ---- Spurious response in IDLE ----
      mem_resp_valid = 1;
      settle();
      check1("sp_if_resp", if_resp_valid, 1'b0);
      check1("sp_d_resp", d_resp_valid, 1'b0);
      tick();
      mem_resp_valid = 0;
      d_req_valid = 1; d_req_addr = 32'h4200;
      settle();
      check1("sp_still_idle", d_req_ready, 1'b1);
      tick();
      d_req_valid = 0; mem_resp_valid = 1;
      settle();
      tick();
      mem_resp_valid = 0;

      // ---- Reset in BUSY_D with a non-zero starvation count ----
      if_req_valid = 1; d_req_valid = 1;
      run_txn(g_if, g_d);
      run_txn(g_if, g_d);
      settle();
      check1("rmid_third_d_accept", d_req_ready, 1'b1);
      tick();                       // now BUSY_D, count = 3
      rst = 1; mem_resp_valid = 1;
      settle();
      check1("rmid_mem_req_valid", mem_req_valid, 1'b0);
      check1("rmid_if_req_ready", if_req_ready, 1'b0);
      check1("rmid_d_req_ready", d_req_ready, 1'b0);
      check1("rmid_if_resp_valid", if_resp_valid, 1'b0);
      check1("rmid_d_resp_valid", d_resp_valid, 1'b0);
      tick();
      rst = 0; mem_resp_valid = 0;
      settle();
      check1("rmid_idle_after", mem_req_valid, 1'b1);
      // Cleared count means four data grants before fetch gets one.
      pattern = 10'b0000010000;
      for (int i = 0; i < 5; i++) begin
         run_txn(g_if, g_d);
         check1($sformatf("rmid_if_grant_%0d", i), g_if, pattern[i]);
         check1($sformatf("rmid_d_grant_%0d", i), g_d, !pattern[i]);
      end
      if_req_valid = 0; d_req_valid = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
